// File: rtl/serial_sub_unit_pkg.sv
// serial_sub_unit_pkg: shared FSM state encoding and default operand width
package serial_sub_unit_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_sub_bit.sv
// full_sub_bit: combinational 1-bit full subtractor (D = A - B - BorrowIn)
module full_sub_bit (
  input  logic A,
  input  logic B,
  input  logic BorrowIn,
  output logic D,
  output logic BorrowOut
);
  assign D = A ^ B ^ BorrowIn;
  assign BorrowOut = (~A & B) | ((~A | B) & BorrowIn);
endmodule

// File: rtl/serial_sub_unit.sv
// serial_sub_unit: bit-serial WIDTH-bit subtractor, one bit per clock LSB first, registered borrow
module serial_sub_unit
  import serial_sub_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic brw_q, brw_d, bout_q, bout_d, d_bit, bo_bit, last;
  full_sub_bit u_cell (
    .A(a_q[0]),
    .B(b_q[0]),
    .BorrowIn(brw_q),
    .D(d_bit),
    .BorrowOut(bo_bit)
  );
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    cnt_d = cnt_q;
    brw_d = brw_q;
    bout_d = bout_q;
    if (state_q == IDLE && start) begin
      state_d = SHIFT;
      a_d = a;
      b_d = b;
      brw_d = bin;
      cnt_d = '0;
      diff_d = '0;
    end else if (state_q == SHIFT) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      diff_d = {d_bit, diff_q[WIDTH-1:1]};
      brw_d = bo_bit;
      cnt_d = cnt_q + CW'(1);
      state_d = last ? DONE : SHIFT;
      bout_d = last ? bo_bit : bout_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      cnt_q <= '0;
      brw_q <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      cnt_q <= cnt_d;
      brw_q <= brw_d;
      bout_q <= bout_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_serial_sub_unit.sv
// tb_serial_sub_unit: scoreboard bench for 8- and 16-bit serial subtractors
module tb_serial_sub_unit;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start8 = 0, bin8 = 0, busy8, done8, bout8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic start16 = 0, bin16 = 0, busy16, done16, bout16;
  logic [15:0] a16 = 0, b16 = 0, diff16;
  serial_sub_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );
  serial_sub_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] diff;
    logic        bout;
    int          acc;
  } exp_t;
  exp_t q8[$], q16[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input int w, input longint a, input longint b, input longint bi, input int acc);
    exp_t m;
    longint d = a - b - bi;
    m.diff = 32'(d & ((longint'(1) << w) - 1));
    m.bout = d < 0;
    m.acc = acc;
    return m;
  endfunction
  int run8 = 0, run16 = 0;
  logic pd8 = 0, pd16 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      chk("queue_nonempty8", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("diff8", diff8, e.diff);
        chk("bout8", bout8, e.bout);
        chk("latency8", cyc - e.acc, 9);
        chk("busy_len8", run8, 8);
        chk("busy_at_done8", busy8, 0);
      end
      chk("done_pulse8", pd8, 0);
    end
    pd8 = done8;
    if (busy8) run8++;
    else if (!done8) run8 = 0;
  end
  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      chk("queue_nonempty16", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        chk("diff16", diff16, e.diff);
        chk("bout16", bout16, e.bout);
        chk("latency16", cyc - e.acc, 17);
        chk("busy_len16", run16, 16);
      end
      chk("done_pulse16", pd16, 0);
    end
    pd16 = done16;
    if (busy16) run16++;
    else if (!done16) run16 = 0;
  end
  task automatic wait_idle8();
    for (int i = 0; i < 40 && (busy8 || done8); i++) @(negedge clk);
    chk("idle8", busy8 || done8, 0);
  endtask
  task automatic wait_idle16();
    for (int i = 0; i < 60 && (busy16 || done16); i++) @(negedge clk);
    chk("idle16", busy16 || done16, 0);
  endtask
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    wait_idle8();
    a8 = a; b8 = b; bin8 = bi; start8 = 1;
    q8.push_back(model(8, a, b, bi, cyc));
    @(negedge clk);
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask
  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    wait_idle16();
    a16 = a; b16 = b; bin16 = bi; start16 = 1;
    q16.push_back(model(16, a, b, bi, cyc));
    @(negedge clk);
    start16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_bout8", bout8, 0);
    chk("rst_diff16", diff16, 0);
    chk("rst_busy16", busy16, 0);
    rst_n = 1;
    @(negedge clk);
    go8(100, 37, 0);
    wait_idle8();
    for (int i = 0; i < 10; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      chk("hold_diff", diff8, 8'h3F);
      chk("hold_bout", bout8, 0);
      chk("hold_done", done8, 0);
      @(negedge clk);
    end
    go8(5, 9, 0);
    go8(0, 0, 1);
    wait_idle8();
    go8(50, 20, 0);
    repeat (3) @(negedge clk);
    rst_n = 0;
    q8.delete();
    @(negedge clk);
    rst_n = 1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_diff", diff8, 0);
    chk("midrst_bout", bout8, 0);
    repeat (12) @(negedge clk);
    go8(50, 20, 0);
    go8(8'hFF, 8'hFF, 0);
    wait_idle8();
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 10) begin
        a8 = 200; b8 = 1; bin8 = 0;
        q8.push_back(model(8, 200, 1, 0, cyc));
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      start8 = 1;
      @(negedge clk);
    end
    start8 = 0;
    for (int i = 0; i < 500; i++) go8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 500; i++) go16(16'($urandom), 16'($urandom), 1'($urandom));
    go16(16'h0000, 16'hFFFF, 1);
    go16(16'hFFFF, 16'hFFFF, 1);
    repeat (40) @(negedge clk);
    chk("drain8", q8.size(), 0);
    chk("drain16", q16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
